// File: rtl/score_display_ctrl.sv
// score_display_ctrl: turns a binary score into BCD digit codes for the 7-segment decoders.
// It converts serially by shift-add-3 (double-dabble), one bit per clock. It also builds a
// per-digit blank mask (leading-zero suppression, OR-ed with an optional blink phase).
//
// Ports:
//   clk       system clock, rising edge
//   reset     asynchronous active-high reset
//   load      start a conversion of value; while busy the request is held as pending
//   value     binary score, saturated to 10^DIGITS-1
//   blink_en  force all digits off during the blink "off" phase
//   busy      conversion in progress
//   done      one-cycle pulse when bcd/ovf/blank take a new result
//   ovf       the most recent committed value was saturated
//   bcd       digit i is bcd[4i+3:4i]; digit 0 is least significant
//   blank     1 = top level must switch digit i off
module score_display_ctrl #(
  parameter int unsigned WIDTH     = 10,
  parameter int unsigned DIGITS    = 4,
  parameter int unsigned BLINK_DIV = 25000000
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                load,
  input  logic [WIDTH-1:0]    value,
  input  logic                blink_en,
  output logic                busy,
  output logic                done,
  output logic                ovf,
  output logic [4*DIGITS-1:0] bcd,
  output logic [DIGITS-1:0]   blank
);

  localparam int unsigned BcdW   = 4 * DIGITS;
  localparam int unsigned CntW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int unsigned BlinkW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

  localparam logic [CntW-1:0]   LastBit   = CntW'(WIDTH - 1);
  localparam logic [BlinkW-1:0] BlinkLast = BlinkW'(BLINK_DIV - 1);

  localparam logic [1:0] StIdle   = 2'd0;
  localparam logic [1:0] StShift  = 2'd1;
  localparam logic [1:0] StCommit = 2'd2;

  function automatic longint unsigned pow10(input int unsigned n);
    longint unsigned r;
    r = 1;
    for (int unsigned i = 0; i < n; i++) begin
      r = r * 10;
    end
    return r;
  endfunction

  localparam longint unsigned MaxVal = pow10(DIGITS) - 1;
  // If MaxVal does not fit in WIDTH bits, saturation can never trigger, so truncation is harmless.
  localparam logic [WIDTH-1:0] MaxCap = WIDTH'(MaxVal);

  // Reset / leading-zero mask for an all-zero value: every digit off except digit 0.
  localparam logic [DIGITS-1:0] ZeroMask = ~DIGITS'(1);

  logic [1:0]          state_q, state_d;
  logic [WIDTH-1:0]    bin_q, bin_d;
  logic [BcdW-1:0]     work_q, work_d;
  logic [CntW-1:0]     bit_cnt_q, bit_cnt_d;
  logic                sat_q, sat_d;
  logic                pend_q, pend_d;
  logic [WIDTH-1:0]    pend_val_q, pend_val_d;
  logic [BcdW-1:0]     bcd_q, bcd_d;
  logic                ovf_q, ovf_d;
  logic                done_q, done_d;
  logic [DIGITS-1:0]   lz_q, lz_d;
  logic [DIGITS-1:0]   blank_q, blank_d;
  logic [BlinkW-1:0]   blink_cnt_q, blink_cnt_d;
  logic                phase_q, phase_d;

  logic [BcdW-1:0]     work_adj;
  logic [DIGITS-1:0]   lz_new;
  logic                zero_above;
  logic                start;
  logic [WIDTH-1:0]    cap_src;
  logic [WIDTH-1:0]    cap_val;
  logic                cap_sat;

  // Add-3 correction applied to every nibble before each shift.
  always_comb begin
    work_adj = work_q;
    for (int i = 0; i < int'(DIGITS); i++) begin
      if (work_q[4*i +: 4] >= 4'd5) begin
        work_adj[4*i +: 4] = work_q[4*i +: 4] + 4'd3;
      end
    end
  end

  // Leading-zero mask of the finished result; digit 0 always stays lit.
  always_comb begin
    lz_new     = '0;
    zero_above = 1'b1;
    for (int i = int'(DIGITS) - 1; i >= 1; i--) begin
      zero_above = zero_above & (work_q[4*i +: 4] == 4'd0);
      lz_new[i]  = zero_above;
    end
  end

  always_comb begin
    state_d    = state_q;
    bin_d      = bin_q;
    work_d     = work_q;
    bit_cnt_d  = bit_cnt_q;
    sat_d      = sat_q;
    pend_d     = pend_q;
    pend_val_d = pend_val_q;
    bcd_d      = bcd_q;
    ovf_d      = ovf_q;
    lz_d       = lz_q;
    done_d     = 1'b0;
    start      = 1'b0;
    cap_src    = value;

    unique case (state_q)
      StIdle: begin
        start = load;
      end
      StShift: begin
        {work_d, bin_d} = {work_adj, bin_q} << 1;
        if (load) begin
          pend_d     = 1'b1;
          pend_val_d = value;
        end
        if (bit_cnt_q == LastBit) begin
          state_d = StCommit;
        end else begin
          bit_cnt_d = bit_cnt_q + 1'b1;
        end
      end
      StCommit: begin
        bcd_d  = work_q;
        ovf_d  = sat_q;
        lz_d   = lz_new;
        done_d = 1'b1;
        pend_d = 1'b0;
        // A load arriving in this very cycle is the newest request, so it beats the pending one.
        if (pend_q || load) begin
          start   = 1'b1;
          cap_src = load ? value : pend_val_q;
        end else begin
          state_d = StIdle;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    cap_sat = 64'(cap_src) > MaxVal;
    cap_val = cap_sat ? MaxCap : cap_src;

    if (start) begin
      state_d   = StShift;
      bin_d     = cap_val;
      work_d    = '0;
      bit_cnt_d = '0;
      sat_d     = cap_sat;
    end
  end

  // Free-running blink divider; it runs whether or not blinking is enabled.
  always_comb begin
    if (blink_cnt_q == BlinkLast) begin
      blink_cnt_d = '0;
      phase_d     = ~phase_q;
    end else begin
      blink_cnt_d = blink_cnt_q + 1'b1;
      phase_d     = phase_q;
    end
  end

  always_comb begin
    blank_d = lz_d | {DIGITS{blink_en & phase_q}};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= StIdle;
      bin_q       <= '0;
      work_q      <= '0;
      bit_cnt_q   <= '0;
      sat_q       <= 1'b0;
      pend_q      <= 1'b0;
      pend_val_q  <= '0;
      bcd_q       <= '0;
      ovf_q       <= 1'b0;
      done_q      <= 1'b0;
      lz_q        <= ZeroMask;
      blank_q     <= ZeroMask;
      blink_cnt_q <= '0;
      phase_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      bin_q       <= bin_d;
      work_q      <= work_d;
      bit_cnt_q   <= bit_cnt_d;
      sat_q       <= sat_d;
      pend_q      <= pend_d;
      pend_val_q  <= pend_val_d;
      bcd_q       <= bcd_d;
      ovf_q       <= ovf_d;
      done_q      <= done_d;
      lz_q        <= lz_d;
      blank_q     <= blank_d;
      blink_cnt_q <= blink_cnt_d;
      phase_q     <= phase_d;
    end
  end

  assign busy  = (state_q != StIdle);
  assign done  = done_q;
  assign ovf   = ovf_q;
  assign bcd   = bcd_q;
  assign blank = blank_q;

endmodule

// File: tb/tb_score_display_ctrl.sv
// Bench for score_display_ctrl: a 4-digit instance (fast blink) and a 2-digit instance
// (saturation). Expected results are queued at stimulus time; monitors pop them on done.
module tb_score_display_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        load_a, blink_en_a, busy_a, done_a, ovf_a;
  logic [9:0]  value_a;
  logic [15:0] bcd_a;
  logic [3:0]  blank_a;

  logic        load_b, blink_en_b, busy_b, done_b, ovf_b;
  logic [9:0]  value_b;
  logic [7:0]  bcd_b;
  logic [1:0]  blank_b;

  score_display_ctrl #(.WIDTH(10), .DIGITS(4), .BLINK_DIV(4)) dut_a (
    .clk(clk), .reset(reset), .load(load_a), .value(value_a), .blink_en(blink_en_a),
    .busy(busy_a), .done(done_a), .ovf(ovf_a), .bcd(bcd_a), .blank(blank_a)
  );

  score_display_ctrl #(.WIDTH(10), .DIGITS(2), .BLINK_DIV(4)) dut_b (
    .clk(clk), .reset(reset), .load(load_b), .value(value_b), .blink_en(blink_en_b),
    .busy(busy_b), .done(done_b), .ovf(ovf_b), .bcd(bcd_b), .blank(blank_b)
  );

  typedef struct packed {
    logic [15:0] bcd;
    logic [3:0]  blank;
    logic        ovf;
    logic        busy;
  } exp_t;

  exp_t qa[$];
  exp_t qb[$];
  exp_t ea, eb;
  int   checks = 0;
  int   errors = 0;

  // Blink timing reference: divide-by-4 phase, seen on blank one clock later.
  int   m_cnt;
  logic m_phase, m_blink;
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_cnt   <= 0;
      m_phase <= 1'b0;
      m_blink <= 1'b0;
    end else begin
      m_blink <= blink_en_a & m_phase;
      if (m_cnt == 3) begin
        m_cnt   <= 0;
        m_phase <= ~m_phase;
      end else begin
        m_cnt <= m_cnt + 1;
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  task automatic push_a(input logic [15:0] b, input logic [3:0] bl, input logic o,
                        input logic bz);
    exp_t e;
    e.bcd = b; e.blank = bl; e.ovf = o; e.busy = bz;
    qa.push_back(e);
  endtask

  task automatic push_b(input logic [15:0] b, input logic [3:0] bl, input logic o,
                        input logic bz);
    exp_t e;
    e.bcd = b; e.blank = bl; e.ovf = o; e.busy = bz;
    qb.push_back(e);
  endtask

  always @(negedge clk) begin
    if (done_a) begin
      if (qa.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL a_unexpected_done: got bcd %0h, required no done", bcd_a);
      end else begin
        ea = qa.pop_front();
        check("a_bcd", 32'(bcd_a), 32'(ea.bcd));
        check("a_blank", 32'(blank_a), 32'(ea.blank));
        check("a_ovf", 32'(ovf_a), 32'(ea.ovf));
        check("a_busy_at_done", 32'(busy_a), 32'(ea.busy));
      end
    end
    if (done_b) begin
      if (qb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL b_unexpected_done: got bcd %0h, required no done", bcd_b);
      end else begin
        eb = qb.pop_front();
        check("b_bcd", 32'(bcd_b), 32'(eb.bcd));
        check("b_blank", 32'(blank_b), 32'(eb.blank));
        check("b_ovf", 32'(ovf_b), 32'(eb.ovf));
        check("b_busy_at_done", 32'(busy_b), 32'(eb.busy));
      end
    end
  end

  task automatic load_a_t(input logic [9:0] v);
    @(negedge clk);
    load_a  = 1'b1;
    value_a = v;
    @(posedge clk);
    #1;
    load_a = 1'b0;
  endtask

  task automatic load_b_t(input logic [9:0] v);
    @(negedge clk);
    load_b  = 1'b1;
    value_b = v;
    @(posedge clk);
    #1;
    load_b = 1'b0;
  endtask

  task automatic drain_a();
    int n = 0;
    while (qa.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("a_results_outstanding", 32'(qa.size()), 32'd0);
    qa.delete();
    repeat (2) @(negedge clk);
  endtask

  task automatic drain_b();
    int n = 0;
    while (qb.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("b_results_outstanding", 32'(qb.size()), 32'd0);
    qb.delete();
    repeat (2) @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int first, pulses, n_on;
    reset = 1'b1;
    load_a = 1'b0; value_a = '0; blink_en_a = 1'b0;
    load_b = 1'b0; value_b = '0; blink_en_b = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    check("rst_bcd", 32'(bcd_a), 32'h0);
    check("rst_blank", 32'(blank_a), 32'b1110);
    check("rst_busy", 32'(busy_a), 32'd0);
    check("rst_done", 32'(done_a), 32'd0);
    check("rst_ovf", 32'(ovf_a), 32'd0);
    check("rst_blank_b", 32'(blank_b), 32'b10);

    // 987: busy right after the load edge, done exactly 11 edges later for one cycle.
    push_a(16'h0987, 4'b1000, 1'b0, 1'b0);
    load_a_t(10'd987);
    check("busy_after_load", 32'(busy_a), 32'd1);
    check("bcd_held_during_shift", 32'(bcd_a), 32'h0);
    first = 0;
    pulses = 0;
    for (int k = 1; k <= 14; k++) begin
      @(posedge clk);
      #1;
      if (done_a) begin
        pulses++;
        if (first == 0) first = k;
      end
    end
    check("done_latency", 32'(first), 32'd11);
    check("done_width", 32'(pulses), 32'd1);
    drain_a();

    push_a(16'h0005, 4'b1110, 1'b0, 1'b0);
    load_a_t(10'd5);
    drain_a();
    push_a(16'h0000, 4'b1110, 1'b0, 1'b0);
    load_a_t(10'd0);
    drain_a();

    // 456 is overwritten by 789 while busy; the restart keeps busy high at the first done.
    push_a(16'h0123, 4'b1000, 1'b0, 1'b1);
    push_a(16'h0789, 4'b1000, 1'b0, 1'b0);
    load_a_t(10'd123);
    repeat (2) @(negedge clk);
    load_a_t(10'd456);
    repeat (2) @(negedge clk);
    load_a_t(10'd789);
    drain_a();

    push_a(16'h0042, 4'b1100, 1'b0, 1'b0);
    load_a_t(10'd42);
    drain_a();

    @(negedge clk);
    blink_en_a = 1'b1;
    repeat (2) @(negedge clk);
    n_on = 0;
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      check("blink_blank", 32'(blank_a), 32'(4'b1100 | {4{m_blink}}));
      if (blank_a == 4'b1111) n_on++;
    end
    check("blink_on_count", 32'(n_on), 32'd8);
    blink_en_a = 1'b0;
    repeat (2) @(negedge clk);
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      check("blink_off_blank", 32'(blank_a), 32'b1100);
    end

    // Reset during SHIFT with 456 pending: everything clears at once, nothing resumes.
    load_a_t(10'd321);
    repeat (2) @(negedge clk);
    load_a_t(10'd456);
    @(negedge clk);
    #2;
    reset = 1'b1;
    #1;
    check("midrst_bcd", 32'(bcd_a), 32'h0);
    check("midrst_blank", 32'(blank_a), 32'b1110);
    check("midrst_busy", 32'(busy_a), 32'd0);
    check("midrst_done", 32'(done_a), 32'd0);
    check("midrst_ovf", 32'(ovf_a), 32'd0);
    @(negedge clk);
    load_a  = 1'b1;
    value_a = 10'd7;
    @(posedge clk);
    #1;
    check("reset_beats_load", 32'(busy_a), 32'd0);
    load_a = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    repeat (30) @(negedge clk);
    check("pending_dropped_busy", 32'(busy_a), 32'd0);
    check("pending_dropped_bcd", 32'(bcd_a), 32'h0);

    push_b(16'h0099, 4'b0000, 1'b1, 1'b0);
    load_b_t(10'd150);
    drain_b();
    push_b(16'h0042, 4'b0000, 1'b0, 1'b0);
    load_b_t(10'd42);
    drain_b();
    push_b(16'h0007, 4'b0010, 1'b0, 1'b0);
    load_b_t(10'd7);
    drain_b();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
